note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Sits directly downstream of music_ROM and consumes its 8-bit note index (noteout).
- Converts the index into a square-wave tone for the speaker/buzzer pin by looking up a half-period count, then toggling the output each time a free-running counter reaches that count.
- Index 0 and out-of-range indices are rests (silence).
- Also provides a mute/enable input and status outputs for LEDs and debug.

Parameters:
- CNT_W, 20: width of the half-period counter and of the half-period register.
- SIM_SHIFT, 0: right-shift applied to every looked-up half-period. Used to shorten simulation. 0 in synthesis.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  1 = play; 0 = mute and hold counter cleared.
- note_in  in  8  note index. 0 = rest, 1..48 = A2..G#6 chromatic, 49..255 = rest.
- tone  out  1  square-wave audio output.
- active  out  1  high while a non-rest note is sounding and en=1.
- note_chg  out  1  one-cycle pulse when a new note index is registered.

Behaviour:
- Reset (async assert, sync release): note_q=0, hp_q=0, cnt=0, tone=0, active=0, note_chg=0. tone drops to 0 immediately on rst_n fall, even mid-cycle.
- Stage 1, every clk edge:
  - note_q <= note_in.
  - note_chg <= (note_in != note_q).
- Stage 2, edge after stage 1:
  - hp_q <= lut(note_q) >> SIM_SHIFT.
  - If note_chg=1, cnt <= 0 on the same edge (restart).
- Latency: note_in changes before edge E1 → note_q and note_chg updated at E1 → hp_q loaded and cnt cleared at E2 → first toggle at E2 + hp_q cycles.
- Lookup for n in 1..48:
  - o = (n-1)/12, s = (n-1)%12, implemented by comparison, not a divider.
  - half-period = HP_TOP[s] << (3-o).
  - n=0 or n>48 gives 0 (rest).
- Counter:
  - If en=1 and hp_q!=0: when cnt == hp_q-1, cnt <= 0 and tone <= ~tone; otherwise cnt <= cnt+1.
  - If the result of >>SIM_SHIFT is 0 for a valid note, clamp hp_q to 1, so the tone toggles every cycle.
- Rest (hp_q==0): cnt held 0, tone <= 0, active <= 0.
- active <= en && (hp_q!=0), registered, aligned with the hp_q load.
- Note change mid half-period: tone keeps its current level and cnt restarts from 0, giving no runt pulse shorter than one cycle.
- Same index presented repeatedly: no note_chg, no restart; phase stays continuous.
- en=0: cnt <= 0, tone <= 0, active <= 0. note_q and hp_q keep updating.
- en 0→1: counting resumes from cnt=0 with tone=0.
- en rising on the same edge as a note change: both take effect; no special case.
- Widths: max half-period is 56818<<3 = 454544 < 2^19, so it fits in CNT_W=20. Comparison is unsigned.

Decomposition:
- Package music_pkg holds:
  - NOTE_REST=0, NOTE_MAX=48.
  - HP_TOP[0..11] = 56818, 53629, 50619, 47778, 45097, 42566, 40177, 37922, 35793, 33784, 31888, 30098 (A5..G#6 half-periods at 100 MHz).
  - Default CNT_W.
- Sub-module note_period_lut: combinational; 8-bit index in, CNT_W half-period out. Performs the range check, octave/semitone split and shift. It is instantiated once, feeding hp_q.

Test Plan:
- Reset: rst_n low while tone=1 → tone=0 with no clk edge. Release, note_in=0 → tone=0, active=0 indefinitely.
- SIM_SHIFT=0, note_in=37 → note_chg pulse at E1, active=1 at E2, first toggle at E2+56818, then a toggle every 56818 cycles.
- SIM_SHIFT=4, note_in=1 → half-period 28409 (454544>>4). Then note_in=40 mid half-period → cnt restarts, tone level retained, next toggle after 2986 cycles (47778>>4).
- note_in = 0, 49, 200 in turn (from a sounding note) → tone=0 and active=0 by E2. note_chg pulses on each change.
- note_in held at 25 for 3 full periods → exactly one note_chg, toggle spacing constant at 113636 (SIM_SHIFT=0).
- en low for 10 cycles mid-tone → tone=0, active=0 during. After en rises, first toggle after exactly hp_q cycles.

Source files
------------

// File: rtl/music_pkg.sv
// music_pkg: shared constants for the note-to-tone path (rest/max index, top-octave half-periods, counter width)
package music_pkg;
    localparam int         CNT_W_DEF = 20;
    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_MAX  = 8'd48;
    // A5..G#6 half-periods in 100 MHz clock cycles; lower octaves are left shifts of these
    localparam logic [15:0] HP_TOP [12] = '{
        16'd56818, 16'd53629, 16'd50619, 16'd47778, 16'd45097, 16'd42566,
        16'd40177, 16'd37922, 16'd35793, 16'd33784, 16'd31888, 16'd30098
    };
endpackage

// File: rtl/note_period_lut.sv
// note_period_lut: note index -> half-period in clk cycles (0 for rests)
//   note_i : 8-bit note index, 1..48 = A2..G#6, anything else is a rest
//   hp_o   : half-period count, HP_TOP[semitone] << (3 - octave)
module note_period_lut
    import music_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [7:0]       note_i,
    output logic [CNT_W-1:0] hp_o
);
    logic       valid;
    logic [7:0] idx;
    logic [1:0] oct;
    logic [3:0] semi;
    always_comb begin
        valid = (note_i != NOTE_REST) && (note_i <= NOTE_MAX);
        idx   = note_i - 8'd1;
        // octave split by comparison so no divider is inferred
        oct   = idx >= 8'd36 ? 2'd3 : idx >= 8'd24 ? 2'd2 : idx >= 8'd12 ? 2'd1 : 2'd0;
        semi  = 4'(idx - 8'(oct) * 8'd12);
        hp_o  = valid ? CNT_W'(HP_TOP[semi]) << (2'd3 - oct) : '0;
    end
endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator driven by a music ROM note index
//   clk, rst_n : 100 MHz clock, async active-low reset
//   en         : 1 = play, 0 = mute with counter cleared
//   note_in    : note index (0 / >48 = rest)
//   tone       : square-wave output
//   active     : a non-rest note is sounding with en=1
//   note_chg   : one-cycle pulse when a new index is registered
module note_tone_gen
    import music_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SIM_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] note_in,
    output logic       tone,
    output logic       active,
    output logic       note_chg
);
    logic [7:0]       note_q, note_d;
    logic             note_chg_q, note_chg_d;
    logic [CNT_W-1:0] hp_q, hp_d, cnt_q, cnt_d, lut_hp, shifted;
    logic             tone_q, tone_d, active_q, active_d;
    logic             silent, wrap;

    note_period_lut #(.CNT_W(CNT_W)) u_lut (
        .note_i (note_q),
        .hp_o   (lut_hp)
    );

    always_comb begin
        note_d     = note_in;
        note_chg_d = note_in != note_q;
        shifted    = lut_hp >> SIM_SHIFT;
        // a valid note never collapses to a rest when scaled down for simulation
        hp_d       = (lut_hp != '0 && shifted == '0) ? CNT_W'(1) : shifted;
        // silence follows the half-period being loaded so a rest mutes on the same edge
        silent     = !en || hp_d == '0;
        wrap       = cnt_q == hp_q - 1'b1;
        // a note change restarts the count but keeps the tone level (no runt pulse)
        cnt_d      = (silent || note_chg_q || wrap) ? '0 : cnt_q + 1'b1;
        tone_d     = silent ? 1'b0 : (!note_chg_q && wrap) ? ~tone_q : tone_q;
        active_d   = !silent;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q     <= '0;
            note_chg_q <= 1'b0;
            hp_q       <= '0;
            cnt_q      <= '0;
            tone_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            note_q     <= note_d;
            note_chg_q <= note_chg_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            tone_q     <= tone_d;
            active_q   <= active_d;
        end
    end

    assign tone     = tone_q;
    assign active   = active_q;
    assign note_chg = note_chg_q;
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed table-driven bench for note_tone_gen (SIM_SHIFT=5)
module tb_note_tone_gen;
    localparam int BOUND = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] note_in = 8'd0;
    logic       tone, active, note_chg;
    int         checks = 0;
    int         failures = 0;
    int         chg_seen = 0;

    always #5 clk = ~clk;

    note_tone_gen #(.CNT_W(20), .SIM_SHIFT(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .note_in  (note_in),
        .tone     (tone),
        .active   (active),
        .note_chg (note_chg)
    );

    always @(negedge clk) if (note_chg) chg_seen++;

    typedef struct {
        logic [7:0] note;
        int         hp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic measure(output int k);
        logic t0;
        t0 = tone;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (tone == t0 && k <= BOUND);
    endtask

    task automatic change(input logic [7:0] n, input int hp);
        @(negedge clk) note_in = n;
        @(posedge clk);
        #1 chk($sformatf("note_chg_e1[%0d]", n), note_chg, 1);
        @(posedge clk);
        #1 chk($sformatf("note_chg_e2[%0d]", n), note_chg, 0);
        chk($sformatf("active_e2[%0d]", n), active, hp != 0);
    endtask

    task automatic apply(input logic [7:0] n, input int hp);
        int k;
        change(n, hp);
        if (hp == 0) begin
            chk($sformatf("rest_tone_e2[%0d]", n), tone, 0);
            repeat (20) @(posedge clk);
            #1 chk($sformatf("rest_hold[%0d]", n), {tone, active}, 0);
        end else begin
            measure(k);
            chk($sformatf("first_toggle[%0d]", n), k, hp);
            measure(k);
            chk($sformatf("toggle_spacing[%0d]", n), k, hp);
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   k;
        logic lvl;
        logic bad;
        vecs = '{
            '{8'd37, 1775}, '{8'd48, 940}, '{8'd44, 1185}, '{8'd41, 1409},
            '{8'd30, 2660}, '{8'd0, 0}, '{8'd49, 0}, '{8'd200, 0}, '{8'd37, 1775}
        };

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {tone, active, note_chg}, 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 bad |= tone | active | note_chg;
        end
        chk("idle_rest_after_reset", bad, 0);

        foreach (vecs[i]) apply(vecs[i].note, vecs[i].hp);

        apply(8'd0, 0);
        change(8'd1, 14204);
        repeat (1000) @(posedge clk);
        #1 chk("note1_no_toggle_yet", tone, 0);
        lvl = tone;
        change(8'd40, 1493);
        chk("mid_change_keeps_level_lo", tone, lvl);
        measure(k);
        chk("mid_change_restart_40", k, 1493);
        repeat (500) @(posedge clk);
        #1 lvl = tone;
        chk("tone_high_before_change", lvl, 1);
        change(8'd37, 1775);
        chk("mid_change_keeps_level_hi", tone, lvl);
        measure(k);
        chk("mid_change_restart_37", k, 1775);

        chg_seen = 0;
        change(8'd25, 3551);
        for (int i = 0; i < 6; i++) begin
            measure(k);
            chk($sformatf("held25_spacing%0d", i), k, 3551);
        end
        chk("held25_single_chg", chg_seen, 1);

        repeat (100) @(posedge clk);
        @(negedge clk) en = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 bad |= tone | active;
        end
        chk("muted_silent", bad, 0);
        @(negedge clk) en = 1'b1;
        @(posedge clk);
        #1 chk("unmute_active", active, 1);
        chk("unmute_tone_low", tone, 0);
        measure(k);
        chk("unmute_first_toggle", k + 1, 3551);

        chk("pre_reset_tone", tone, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {tone, active, note_chg}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
